// File: rtl/stc_pkg.sv
// Shared definitions for the sparse tensor core load path: loader states and
// the beat counts that fix the stream ordering for producers and the loader.
package stc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CU,
    ST_A_DATA,
    ST_A_CIDX,
    ST_B,
    ST_C,
    ST_DONE
  } stc_state_e;

  localparam int unsigned STC_M       = 16;
  localparam int unsigned STC_K       = 16;
  localparam int unsigned STC_N       = 16;
  localparam int unsigned STC_DW_MEM  = 512;
  localparam int unsigned STC_DW_DATA = 32;
  localparam int unsigned STC_DW_IDX  = 4;

  function automatic int unsigned calc_a_dbeats(int unsigned m, int unsigned k,
                                                int unsigned dw_data, int unsigned dw_mem);
    return (m * k * dw_data) / dw_mem;
  endfunction

  function automatic int unsigned calc_a_cbeats(int unsigned m, int unsigned k,
                                                int unsigned dw_idx, int unsigned dw_mem);
    return (m * k * dw_idx) / dw_mem;
  endfunction

  function automatic int unsigned calc_b_beats(int unsigned k);
    return k;
  endfunction

  function automatic int unsigned calc_c_beats(int unsigned m);
    return m;
  endfunction

  localparam int unsigned A_DBEATS = calc_a_dbeats(STC_M, STC_K, STC_DW_DATA, STC_DW_MEM);
  localparam int unsigned A_CBEATS = calc_a_cbeats(STC_M, STC_K, STC_DW_IDX, STC_DW_MEM);
  localparam int unsigned B_BEATS  = calc_b_beats(STC_K);
  localparam int unsigned C_BEATS  = calc_c_beats(STC_M);

endpackage

// File: rtl/stc_tile_loader.sv
// Converts a valid/ready memory stream into the sparse tensor core's per-buffer
// write strobes: CU word, A data, A column indices, B rows and optional C rows.
module stc_tile_loader
  import stc_pkg::*;
#(
  parameter int unsigned M       = 16,
  parameter int unsigned K       = 16,
  parameter int unsigned N       = 16,
  parameter int unsigned DW_MEM  = 512,
  parameter int unsigned DW_DATA = 32,
  parameter int unsigned DW_IDX  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 load_c,
  output logic                 busy,
  output logic                 done,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [DW_MEM-1:0]    mem_data,
  output logic                 write_cu,
  output logic [DW_MEM-1:0]    cu_input,
  output logic                 write_a_data_en,
  output logic                 write_a_cidx_en,
  output logic [DW_MEM-1:0]    A_data_input,
  output logic [DW_MEM-1:0]    A_colidx_input,
  output logic [DW_IDX-1:0]    A_idx,
  output logic                 write_b,
  output logic [DW_MEM-1:0]    B_input,
  output logic [DW_IDX-1:0]    B_row,
  output logic                 write_c,
  output logic [N*DW_DATA-1:0] in_c,
  output logic [DW_IDX-1:0]    in_c_row
);

  localparam int unsigned NB_A_DATA = calc_a_dbeats(M, K, DW_DATA, DW_MEM);
  localparam int unsigned NB_A_CIDX = calc_a_cbeats(M, K, DW_IDX, DW_MEM);
  localparam int unsigned NB_B      = calc_b_beats(K);
  localparam int unsigned NB_C      = calc_c_beats(M);

  function automatic int unsigned max4(int unsigned a, int unsigned b,
                                       int unsigned c, int unsigned d);
    int unsigned r;
    r = a;
    if (b > r) r = b;
    if (c > r) r = c;
    if (d > r) r = d;
    return r;
  endfunction

  localparam int unsigned CNT_W = $clog2(max4(NB_A_DATA, NB_A_CIDX, NB_B, NB_C) + 1);

  if ((M * K * DW_DATA) % DW_MEM != 0) begin : g_bad_a_data
    $error("stc_tile_loader: M*K*DW_DATA must be a multiple of DW_MEM");
  end
  if ((M * K * DW_IDX) % DW_MEM != 0) begin : g_bad_a_cidx
    $error("stc_tile_loader: M*K*DW_IDX must be a multiple of DW_MEM");
  end
  if (N * DW_DATA > DW_MEM) begin : g_bad_c_width
    $error("stc_tile_loader: N*DW_DATA must not exceed DW_MEM");
  end

  stc_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             load_c_q;
  logic             accept;
  logic             last_beat;

  assign mem_ready = (state == ST_CU) || (state == ST_A_DATA) || (state == ST_A_CIDX) ||
                     (state == ST_B)  || (state == ST_C);
  assign accept    = mem_valid && mem_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_comb begin
    last_beat = 1'b0;
    unique case (state)
      ST_CU:     last_beat = 1'b1;
      ST_A_DATA: last_beat = (cnt == CNT_W'(NB_A_DATA - 1));
      ST_A_CIDX: last_beat = (cnt == CNT_W'(NB_A_CIDX - 1));
      ST_B:      last_beat = (cnt == CNT_W'(NB_B - 1));
      ST_C:      last_beat = (cnt == CNT_W'(NB_C - 1));
      default:   last_beat = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (start) state_n = ST_CU;
      ST_CU:     if (accept) state_n = ST_A_DATA;
      ST_A_DATA: if (accept && last_beat) state_n = ST_A_CIDX;
      ST_A_CIDX: if (accept && last_beat) state_n = ST_B;
      ST_B:      if (accept && last_beat) state_n = load_c_q ? ST_C : ST_DONE;
      ST_C:      if (accept && last_beat) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Counter restarts on every state change so each section indexes from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      load_c_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (accept)      cnt <= cnt + CNT_W'(1);
      if (state == ST_IDLE && start) load_c_q <= load_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_cu        <= 1'b0;
      write_a_data_en <= 1'b0;
      write_a_cidx_en <= 1'b0;
      write_b         <= 1'b0;
      write_c         <= 1'b0;
      cu_input        <= '0;
      A_data_input    <= '0;
      A_colidx_input  <= '0;
      A_idx           <= '0;
      B_input         <= '0;
      B_row           <= '0;
      in_c            <= '0;
      in_c_row        <= '0;
    end else begin
      write_cu        <= accept && (state == ST_CU);
      write_a_data_en <= accept && (state == ST_A_DATA);
      write_a_cidx_en <= accept && (state == ST_A_CIDX);
      write_b         <= accept && (state == ST_B);
      write_c         <= accept && (state == ST_C);
      if (accept) begin
        unique case (state)
          ST_CU:     cu_input <= mem_data;
          ST_A_DATA: begin
            A_data_input <= mem_data;
            A_idx        <= DW_IDX'(cnt);
          end
          ST_A_CIDX: begin
            A_colidx_input <= mem_data;
            A_idx          <= DW_IDX'(cnt);
          end
          ST_B: begin
            B_input <= mem_data;
            B_row   <= DW_IDX'(cnt);
          end
          ST_C: begin
            in_c     <= mem_data[N*DW_DATA-1:0];
            in_c_row <= DW_IDX'(cnt);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stc_tile_loader.sv
// Directed bench for stc_tile_loader: full loads, gapped stream, ignored starts,
// back-to-back tiles and reset in the middle of a load.
module tb_stc_tile_loader;

  localparam int unsigned M = 16, K = 16, N = 16;
  localparam int unsigned DW_MEM = 512, DW_DATA = 32, DW_IDX = 4;

  logic                 clk = 1'b0;
  logic                 reset, start, load_c;
  logic                 busy, done;
  logic                 mem_valid, mem_ready;
  logic [DW_MEM-1:0]    mem_data;
  logic                 write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c;
  logic [DW_MEM-1:0]    cu_input, A_data_input, A_colidx_input, B_input;
  logic [N*DW_DATA-1:0] in_c;
  logic [DW_IDX-1:0]    A_idx, B_row, in_c_row;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  stc_tile_loader #(
    .M(M), .K(K), .N(N), .DW_MEM(DW_MEM), .DW_DATA(DW_DATA), .DW_IDX(DW_IDX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_c(load_c),
    .busy(busy), .done(done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .write_cu(write_cu), .cu_input(cu_input),
    .write_a_data_en(write_a_data_en), .write_a_cidx_en(write_a_cidx_en),
    .A_data_input(A_data_input), .A_colidx_input(A_colidx_input), .A_idx(A_idx),
    .write_b(write_b), .B_input(B_input), .B_row(B_row),
    .write_c(write_c), .in_c(in_c), .in_c_row(in_c_row)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW_MEM-1:0] pat(input int k);
    logic [31:0] w;
    w = k;
    return {16{w}};
  endfunction

  // Streams one tile and checks every strobe against the beat order
  // CU, 16 A data, 2 A cidx, 16 B, optional 16 C.
  task automatic drive_tile(input bit lc, input int gap_pct, input bit poke,
                            input string tag, output int t0, output int t_done,
                            output int last_hs);
    int total, k, prev_k, budget, sel, exp_idx;
    bit hs, prev_hs, exp_done;
    logic [4:0] exp_str, got_str;
    logic [DW_MEM-1:0] got_data, exp_data;
    logic [DW_IDX-1:0] got_idx;
    total = lc ? 51 : 35;
    k = 0; prev_k = 0; prev_hs = 0; budget = 0; t_done = -1; last_hs = -1;
    @(negedge clk);
    start = 1'b1; load_c = lc; t0 = cyc;
    @(negedge clk);
    start = 1'b0; load_c = 1'b0;
    while (1) begin
      sel = 0; exp_idx = 0;
      if (prev_k == 0)       sel = 0;
      else if (prev_k < 17) begin sel = 1; exp_idx = prev_k - 1;  end
      else if (prev_k < 19) begin sel = 2; exp_idx = prev_k - 17; end
      else if (prev_k < 35) begin sel = 3; exp_idx = prev_k - 19; end
      else                  begin sel = 4; exp_idx = prev_k - 35; end
      exp_str = prev_hs ? (5'b10000 >> sel) : 5'b00000;
      got_str = {write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c};
      checks++;
      if (got_str !== exp_str) begin
        errors++;
        $display("FAIL %s strobes beat %0d: got %b expected %b", tag, prev_k, got_str, exp_str);
      end
      if (prev_hs) begin
        exp_data = pat(prev_k);
        got_idx  = '0;
        case (sel)
          0: got_data = cu_input;
          1: begin got_data = A_data_input;   got_idx = A_idx;    end
          2: begin got_data = A_colidx_input; got_idx = A_idx;    end
          3: begin got_data = B_input;        got_idx = B_row;    end
          default: begin got_data = in_c;     got_idx = in_c_row; end
        endcase
        checks++;
        if (got_data !== exp_data) begin
          errors++;
          $display("FAIL %s payload beat %0d: got %h expected %h", tag, prev_k,
                   got_data[63:0], exp_data[63:0]);
        end
        checks++;
        if (got_idx !== DW_IDX'(exp_idx)) begin
          errors++;
          $display("FAIL %s index beat %0d: got %0d expected %0d", tag, prev_k, got_idx, exp_idx);
        end
      end
      exp_done = prev_hs && (prev_k == total - 1);
      checks++;
      if (done !== exp_done || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s done/busy beat %0d: got %b/%b expected %b/1", tag, prev_k,
                 done, busy, exp_done);
      end
      if (exp_done) begin
        t_done = cyc;
        if (poke) start = 1'b1;
        break;
      end
      budget++;
      if (budget > 1000) begin
        errors++;
        $display("FAIL %s timeout: accepted %0d of %0d beats", tag, k, total);
        break;
      end
      mem_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      mem_data  = pat(k);
      start     = (poke && k == 25) ? 1'b1 : 1'b0;
      hs        = mem_valid && mem_ready;
      prev_hs   = hs;
      prev_k    = k;
      if (hs) begin
        last_hs = cyc;
        k++;
      end
      @(negedge clk);
    end
    mem_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, mem_ready, done, write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c}
        !== 8'b0) begin
      errors++;
      $display("FAIL %s idle: busy %b ready %b done %b strobes %b expected all 0", tag,
               busy, mem_ready, done,
               {write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; load_c = 1'b0; mem_valid = 1'b1; mem_data = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mem_ready, write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c}
        !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {busy, done, mem_ready, write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c});
    end
    checks++;
    if ({cu_input, A_data_input, A_colidx_input, B_input, in_c, A_idx, B_row, in_c_row} !== '0) begin
      errors++;
      $display("FAIL reset_buses: got nonzero expected 0 (cu %h B %h)", cu_input[31:0], B_input[31:0]);
    end
    reset = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_load;
    int t0, td, lh;
    drive_tile(1'b1, 0, 1'b0, "full", t0, td, lh);
    checks++;
    if (td - t0 !== 52) begin
      errors++;
      $display("FAIL full done_latency: got %0d expected 52", td - t0);
    end
    check_idle("full_after");
  endtask

  task automatic test_no_c;
    int t0, td, lh;
    drive_tile(1'b0, 0, 1'b0, "no_c", t0, td, lh);
    checks++;
    if (td - t0 !== 36) begin
      errors++;
      $display("FAIL no_c done_latency: got %0d expected 36", td - t0);
    end
    check_idle("no_c_after");
    check_idle("no_c_after2");
  endtask

  task automatic test_gaps;
    int t0, td, lh;
    drive_tile(1'b1, 50, 1'b0, "gaps", t0, td, lh);
    checks++;
    if (td !== lh + 1) begin
      errors++;
      $display("FAIL gaps done_cycle: got %0d expected %0d", td, lh + 1);
    end
    check_idle("gaps_after");
  endtask

  task automatic test_start_ignored;
    int t0, td, lh;
    drive_tile(1'b0, 0, 1'b1, "poke", t0, td, lh);
    checks++;
    if (td - t0 !== 36) begin
      errors++;
      $display("FAIL poke done_latency: got %0d expected 36", td - t0);
    end
    check_idle("poke_after_done");
    check_idle("poke_after_done2");
  endtask

  task automatic test_back_to_back;
    int t0, td, lh, t0b, tdb, lhb;
    drive_tile(1'b0, 0, 1'b0, "b2b_first", t0, td, lh);
    drive_tile(1'b1, 0, 1'b0, "b2b_second", t0b, tdb, lhb);
    checks++;
    if (t0b !== td + 1 || tdb - t0b !== 52) begin
      errors++;
      $display("FAIL b2b timing: start %0d done %0d expected start %0d done %0d",
               t0b, tdb, td + 1, td + 53);
    end
    check_idle("b2b_after");
  endtask

  task automatic test_reset_mid;
    int t0, td, lh;
    @(negedge clk);
    start = 1'b1; load_c = 1'b1;
    @(negedge clk);
    start = 1'b0; load_c = 1'b0;
    // 24 beats: CU, 16 A data, 2 A cidx, B rows 0..4
    for (int i = 0; i < 24; i++) begin
      mem_valid = 1'b1; mem_data = pat(i);
      @(negedge clk);
    end
    checks++;
    if (write_b !== 1'b1 || B_row !== 4'd4) begin
      errors++;
      $display("FAIL reset_mid pre: write_b %b B_row %0d expected 1/4", write_b, B_row);
    end
    reset = 1'b1; mem_data = pat(24);
    @(negedge clk);
    reset = 1'b0; mem_valid = 1'b0;
    checks++;
    if ({busy, mem_ready, done, write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c}
        !== 8'b0 || B_input !== '0) begin
      errors++;
      $display("FAIL reset_mid post: busy %b ready %b done %b strobes %b B %h expected all 0",
               busy, mem_ready, done,
               {write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c}, B_input[31:0]);
    end
    drive_tile(1'b1, 0, 1'b0, "after_reset", t0, td, lh);
    checks++;
    if (td - t0 !== 52) begin
      errors++;
      $display("FAIL after_reset done_latency: got %0d expected 52", td - t0);
    end
    check_idle("after_reset_idle");
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_no_c;
    test_gaps;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
